// File: rtl/ex_stage_mc.sv
// Execute stage: latches decoded control/operands, computes ALU/shift results, flags and branch
// target, drives data-memory requests, and runs an iterative shift-add multiply that stalls upstream.
module ex_stage_mc #(
    parameter int W      = 32,
    parameter int SHW    = 5,
    parameter int MUL_EN = 1
) (
    input  logic           CLOCK,
    input  logic           RESET,
    input  logic           STALL,
    input  logic           FLUSH,
    input  logic           IN_VALID,
    input  logic [W-1:0]   PC_M2,
    input  logic           RW,
    input  logic [4:0]     DA,
    input  logic [1:0]     MD,
    input  logic [1:0]     BS,
    input  logic           PS,
    input  logic           MW,
    input  logic [4:0]     FS,
    input  logic [SHW-1:0] SH,
    input  logic [W-1:0]   BUS_A,
    input  logic [W-1:0]   BUS_B,
    output logic           BUSY,
    output logic           OUT_VALID,
    output logic [W-1:0]   BrA,
    output logic [W-1:0]   RAA,
    output logic           RW_out,
    output logic [4:0]     DA_out,
    output logic [1:0]     MD_out,
    output logic           PS_out,
    output logic           BS_one,
    output logic           BS_zero,
    output logic           Z,
    output logic           V,
    output logic           N,
    output logic           C,
    output logic           VxorN,
    output logic [W-1:0]   F,
    output logic [W-1:0]   MEM_ADDR,
    output logic [W-1:0]   MEM_WDATA,
    output logic           MEM_WE
);

    localparam int CW = $clog2(W) + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [4:0] FS_TSA = 5'b00000;
    localparam logic [4:0] FS_INC = 5'b00001;
    localparam logic [4:0] FS_ADD = 5'b00010;
    localparam logic [4:0] FS_SUB = 5'b00101;
    localparam logic [4:0] FS_DEC = 5'b00110;
    localparam logic [4:0] FS_AND = 5'b01000;
    localparam logic [4:0] FS_OR  = 5'b01010;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_NOT = 5'b01110;
    localparam logic [4:0] FS_TSB = 5'b10000;
    localparam logic [4:0] FS_SHR = 5'b10100;
    localparam logic [4:0] FS_SHL = 5'b11000;
    localparam logic [4:0] FS_MUL = 5'b11100;

    function automatic logic [W:0] add_c(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    logic           valid_q, valid_d;
    logic [W-1:0]   pc_q, pc_d;
    logic           rw_q, rw_d;
    logic [4:0]     da_q, da_d;
    logic [1:0]     md_q, md_d;
    logic [1:0]     bs_q, bs_d;
    logic           ps_q, ps_d;
    logic           mw_q, mw_d;
    logic [4:0]     fs_q, fs_d;
    logic [SHW-1:0] sh_q, sh_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [0:0]     state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    assign BUSY = (state_q == S_MUL);

    always_comb begin
        valid_d  = valid_q;
        pc_d     = pc_q;
        rw_d     = rw_q;
        da_d     = da_q;
        md_d     = md_q;
        bs_d     = bs_q;
        ps_d     = ps_q;
        mw_d     = mw_q;
        fs_d     = fs_q;
        sh_d     = sh_q;
        a_d      = a_q;
        b_d      = b_q;
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (FLUSH) begin
            valid_d = 1'b0;
            state_d = S_IDLE;
        end else if (state_q == S_MUL) begin
            // One shift-add step per cycle; the stage register is frozen meanwhile.
            acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = S_IDLE;
        end else if (!STALL) begin
            valid_d = IN_VALID;
            pc_d    = PC_M2;
            rw_d    = RW;
            da_d    = DA;
            md_d    = MD;
            bs_d    = BS;
            ps_d    = PS;
            mw_d    = MW;
            fs_d    = FS;
            sh_d    = SH;
            a_d     = BUS_A;
            b_d     = BUS_B;
            if ((MUL_EN != 0) && IN_VALID && (FS == FS_MUL)) begin
                state_d  = S_MUL;
                acc_d    = '0;
                mcand_d  = BUS_A;
                mplier_d = BUS_B;
                cnt_d    = CW'(W);
            end
        end
    end

    // Stage register boundary: operand fetch -> execute
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rw_q     <= 1'b0;
            da_q     <= '0;
            md_q     <= '0;
            bs_q     <= '0;
            ps_q     <= 1'b0;
            mw_q     <= 1'b0;
            fs_q     <= '0;
            sh_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rw_q     <= rw_d;
            da_q     <= da_d;
            md_q     <= md_d;
            bs_q     <= bs_d;
            ps_q     <= ps_d;
            mw_q     <= mw_d;
            fs_q     <= fs_d;
            sh_q     <= sh_d;
            a_q      <= a_d;
            b_q      <= b_d;
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    logic [W-1:0] y_s;
    logic         cin_s;
    logic         arith_s;
    logic [W:0]   sum_s;
    logic [W-1:0] f_s;

    // All arithmetic codes share one adder so carry/overflow come from a single place.
    always_comb begin
        y_s     = '0;
        cin_s   = 1'b0;
        arith_s = 1'b0;
        case (fs_q)
            FS_TSA: arith_s = 1'b1;
            FS_INC: begin arith_s = 1'b1; cin_s = 1'b1; end
            FS_ADD: begin arith_s = 1'b1; y_s = b_q; end
            FS_SUB: begin arith_s = 1'b1; y_s = ~b_q; cin_s = 1'b1; end
            FS_DEC: begin arith_s = 1'b1; y_s = '1; end
            default: ;
        endcase
        sum_s = add_c(a_q, y_s, cin_s);
        case (fs_q)
            FS_TSA, FS_INC, FS_ADD, FS_SUB, FS_DEC: f_s = sum_s[W-1:0];
            FS_AND:  f_s = a_q & b_q;
            FS_OR:   f_s = a_q | b_q;
            FS_XOR:  f_s = a_q ^ b_q;
            FS_NOT:  f_s = ~a_q;
            FS_TSB:  f_s = b_q;
            FS_SHR:  f_s = a_q >> sh_q;
            FS_SHL:  f_s = a_q << sh_q;
            FS_MUL:  f_s = (MUL_EN != 0) ? acc_q : '0;
            default: f_s = '0;
        endcase
    end

    assign F         = f_s;
    assign Z         = valid_q & (f_s == '0);
    assign N         = valid_q & f_s[W-1];
    assign C         = valid_q & arith_s & sum_s[W];
    assign V         = valid_q & arith_s & (a_q[W-1] == y_s[W-1]) & (sum_s[W-1] != a_q[W-1]);
    assign VxorN     = V ^ N;

    assign OUT_VALID = valid_q & ~BUSY;
    assign BrA       = pc_q + b_q;
    assign RAA       = a_q;
    assign RW_out    = rw_q & OUT_VALID;
    assign DA_out    = da_q;
    assign MD_out    = md_q;
    assign PS_out    = ps_q;
    assign BS_one    = bs_q[1];
    assign BS_zero   = bs_q[0];
    assign MEM_ADDR  = a_q;
    assign MEM_WDATA = b_q;
    assign MEM_WE    = mw_q & OUT_VALID;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Self-checking bench for ex_stage_mc: table-driven ALU vectors through a scoreboard queue,
// plus hand-written reset, stall, multiply and flush sequences.
module tb_ex_stage_mc;

    localparam int W   = 32;
    localparam int SHW = 5;

    logic           CLOCK = 1'b0;
    logic           RESET, STALL, FLUSH, IN_VALID;
    logic [W-1:0]   PC_M2;
    logic           RW, PS, MW;
    logic [4:0]     DA, FS;
    logic [1:0]     MD, BS;
    logic [SHW-1:0] SH;
    logic [W-1:0]   BUS_A, BUS_B;
    logic           BUSY, OUT_VALID, RW_out, PS_out, BS_one, BS_zero;
    logic [W-1:0]   BrA, RAA, F, MEM_ADDR, MEM_WDATA;
    logic [4:0]     DA_out;
    logic [1:0]     MD_out;
    logic           Z, V, N, C, VxorN, MEM_WE;

    ex_stage_mc #(.W(W), .SHW(SHW), .MUL_EN(1)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .STALL(STALL), .FLUSH(FLUSH), .IN_VALID(IN_VALID),
        .PC_M2(PC_M2), .RW(RW), .DA(DA), .MD(MD), .BS(BS), .PS(PS), .MW(MW), .FS(FS),
        .SH(SH), .BUS_A(BUS_A), .BUS_B(BUS_B), .BUSY(BUSY), .OUT_VALID(OUT_VALID),
        .BrA(BrA), .RAA(RAA), .RW_out(RW_out), .DA_out(DA_out), .MD_out(MD_out),
        .PS_out(PS_out), .BS_one(BS_one), .BS_zero(BS_zero), .Z(Z), .V(V), .N(N), .C(C),
        .VxorN(VxorN), .F(F), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WE(MEM_WE)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [4:0]     fs;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [SHW-1:0] sh;
        logic [W-1:0]   f;
        logic           z, n, c, v;
    } vec_t;

    typedef struct {
        logic [W-1:0] f;
        logic [5:0]   flags;  // {OUT_VALID, Z, N, C, V, VxorN}
    } exp_t;

    vec_t vecs[18];
    exp_t sbq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drive(input logic [4:0] fs, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [SHW-1:0] sh, input logic vld);
        FS = fs; BUS_A = a; BUS_B = b; SH = sh; IN_VALID = vld;
    endtask

    initial begin
        exp_t e;
        int   busy_cnt;
        logic ov_bad;
        logic [W-1:0] bra_hold, f_hold;

        vecs[0]  = '{5'b00010, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 0, 1, 0, 1};
        vecs[1]  = '{5'b00101, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 1, 0, 1, 0};
        vecs[2]  = '{5'b00101, 32'h00000000, 32'h00000001, 5'd0, 32'hFFFFFFFF, 0, 1, 0, 0};
        vecs[3]  = '{5'b00001, 32'hFFFFFFFF, 32'h00000000, 5'd0, 32'h00000000, 1, 0, 1, 0};
        vecs[4]  = '{5'b00110, 32'h80000000, 32'h00000000, 5'd0, 32'h7FFFFFFF, 0, 0, 1, 1};
        vecs[5]  = '{5'b00000, 32'h12345678, 32'h00000009, 5'd0, 32'h12345678, 0, 0, 0, 0};
        vecs[6]  = '{5'b01000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 0, 1, 0, 0};
        vecs[7]  = '{5'b01010, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0, 0, 1, 0, 0};
        vecs[8]  = '{5'b01100, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0, 0, 0, 0, 0};
        vecs[9]  = '{5'b01110, 32'hF0F0F0F0, 32'h00000000, 5'd0, 32'h0F0F0F0F, 0, 0, 0, 0};
        vecs[10] = '{5'b10000, 32'h00000001, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF, 0, 1, 0, 0};
        vecs[11] = '{5'b10100, 32'h80000001, 32'h00000000, 5'd4, 32'h08000000, 0, 0, 0, 0};
        vecs[12] = '{5'b11000, 32'h80000001, 32'h00000000, 5'd4, 32'h00000010, 0, 0, 0, 0};
        vecs[13] = '{5'b11111, 32'h00000005, 32'h00000006, 5'd0, 32'h00000000, 1, 0, 0, 0};
        vecs[14] = '{5'b00010, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1, 0, 1, 0};
        vecs[15] = '{5'b00010, 32'h80000000, 32'h80000000, 5'd0, 32'h00000000, 1, 0, 1, 1};
        vecs[16] = '{5'b00101, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 0, 0, 1, 1};
        vecs[17] = '{5'b10100, 32'hFFFFFFFF, 32'h00000000, 5'd31, 32'h00000001, 0, 0, 0, 0};

        // Reset with random inputs on the bus.
        RESET = 1'b1; STALL = 1'b0; FLUSH = 1'b0;
        PC_M2 = $urandom; RW = 1'b1; DA = 5'd7; MD = 2'd3; BS = 2'd3; PS = 1'b1; MW = 1'b1;
        drive(5'(($urandom)), $urandom, $urandom, 5'($urandom), 1'b1);
        tick();
        tick();
        check("rst_busy",    BUSY, 0);
        check("rst_ovalid",  OUT_VALID, 0);
        check("rst_F",       F, 0);
        check("rst_BrA",     BrA, 0);
        check("rst_flags",   {Z, N, C, V, VxorN}, 0);
        check("rst_we_rw",   {MEM_WE, RW_out}, 0);
        check("rst_addr",    {MEM_ADDR ^ RAA ^ MEM_WDATA}, 0);
        check("rst_ctrl",    {DA_out, MD_out, PS_out, BS_one, BS_zero}, 0);
        RESET = 1'b0;
        MW = 1'b0;

        // ALU vectors: expectation queued at drive time, popped when the result appears.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].sh, 1'b1);
            e.f     = vecs[i].f;
            e.flags = {1'b1, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v, vecs[i].v ^ vecs[i].n};
            sbq.push_back(e);
            tick();
            if (sbq.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                e = sbq.pop_front();
                check($sformatf("vec%0d_F", i), F, e.f);
                check($sformatf("vec%0d_flags", i), {OUT_VALID, Z, N, C, V, VxorN}, e.flags);
            end
        end

        // Branch target / memory request, then held through a 3-cycle stall.
        PC_M2 = 32'h100; MW = 1'b1; RW = 1'b1; DA = 5'h1A; MD = 2'd2; BS = 2'b10; PS = 1'b1;
        drive(5'b00010, 32'h40, 32'hC, 5'd0, 1'b1);
        tick();
        check("br_BrA",   BrA, 32'h10C);
        check("br_addr",  MEM_ADDR, 32'h40);
        check("br_wdata", MEM_WDATA, 32'hC);
        check("br_we",    {OUT_VALID, MEM_WE, RW_out}, 3'b111);
        check("br_ctrl",  {DA_out, MD_out, PS_out, BS_one, BS_zero}, {5'h1A, 2'd2, 1'b1, 1'b1, 1'b0});
        bra_hold = 32'h10C;
        f_hold   = 32'h4C;
        STALL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            PC_M2 = $urandom; MW = 1'b0;
            drive(5'b01110, $urandom, $urandom, 5'($urandom), 1'b1);
            tick();
            check($sformatf("stall%0d_BrA", k), BrA, bra_hold);
            check($sformatf("stall%0d_F", k), F, f_hold);
            check($sformatf("stall%0d_v", k), {OUT_VALID, MEM_WE, MEM_ADDR}, {2'b11, 32'h40});
        end
        STALL = 1'b0;

        // Multiply 3*7: BUSY for W cycles, inputs changed meanwhile must be ignored.
        MW = 1'b1; RW = 1'b1;
        drive(5'b11100, 32'd3, 32'd7, 5'd0, 1'b1);
        tick();
        drive(5'b00010, $urandom, $urandom, 5'd0, 1'b1);
        MW = 1'b0;
        busy_cnt = 0;
        ov_bad   = 1'b0;
        while (BUSY && busy_cnt < 100) begin
            busy_cnt++;
            if (OUT_VALID || MEM_WE) ov_bad = 1'b1;
            if (busy_cnt == 5) STALL = 1'b1;
            if (busy_cnt == 8) STALL = 1'b0;
            tick();
        end
        check("mul_busy_cycles", busy_cnt, W);
        check("mul_ovalid_low",  ov_bad, 0);
        check("mul_F",           F, 32'd21);
        check("mul_done",        {OUT_VALID, MEM_WE, RW_out}, 3'b111);
        IN_VALID = 1'b0;
        tick();

        // Multiply aborted by FLUSH at busy cycle 10.
        MW = 1'b1; RW = 1'b1;
        drive(5'b11100, 32'd3, 32'd7, 5'd0, 1'b1);
        tick();
        check("fl_busy_start", BUSY, 1);
        IN_VALID = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check("fl_busy_c10", BUSY, 1);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check("fl_busy_after", BUSY, 0);
        check("fl_outputs",    {OUT_VALID, MEM_WE, RW_out}, 0);
        check("fl_flags",      {Z, N, C, V}, 0);

        // FLUSH on the same edge as a multiply load: no multiply starts.
        drive(5'b11100, 32'd3, 32'd7, 5'd0, 1'b1);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        IN_VALID = 1'b0;
        check("flmul_busy",   BUSY, 0);
        check("flmul_ovalid", OUT_VALID, 0);
        tick();
        check("flmul_busy2",  BUSY, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
